// File: rtl/div_if.sv
// -----------------------------------------------------------------------------
// div_if: request/response bundle between the EX stage and the div_seq divider.
//
// Signals (suffixes are from the divider's point of view):
//   signed_div_i  1        1 = DIV (signed), 0 = DIVU; sampled with start_i
//   opdata1_i     WIDTH    dividend
//   opdata2_i     WIDTH    divisor
//   start_i       1        request, level-held by EX until ready_o is seen
//   annul_i       1        flush of the in-flight division
//   result_o      2*WIDTH  {remainder, quotient}
//   ready_o       1        result valid
//   busy_o        1        divider not idle (EX stalls on this)
//   divzero_o     1        only with DIV_ZERO_FLAG_EN: result came from a /0
//
// Modports: master = EX stage, slave = divider.
// -----------------------------------------------------------------------------
interface div_if #(
    parameter int WIDTH = 32
);
    logic                   signed_div_i;
    logic [WIDTH-1:0]       opdata1_i;
    logic [WIDTH-1:0]       opdata2_i;
    logic                   start_i;
    logic                   annul_i;
    logic [2*WIDTH-1:0]     result_o;
    logic                   ready_o;
    logic                   busy_o;
`ifdef DIV_ZERO_FLAG_EN
    logic                   divzero_o;
`endif

    modport master (
        output signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
        input  result_o, ready_o, busy_o
`ifdef DIV_ZERO_FLAG_EN
        , input divzero_o
`endif
    );

    modport slave (
        input  signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
        output result_o, ready_o, busy_o
`ifdef DIV_ZERO_FLAG_EN
        , output divzero_o
`endif
    );
endinterface

// File: rtl/div_seq.sv
// -----------------------------------------------------------------------------
// div_seq: multi-cycle radix-2 restoring divider for DIV/DIVU in the EX stage.
// One quotient bit per cycle; WIDTH iterations per division.
//
// Ports:
//   clk   rising-edge clock
//   rst   synchronous active-high reset
//   dbus  div_if.slave: operands/start/annul in, result/ready/busy out
//
// Optional build macro:
//   DIV_ZERO_FLAG_EN  adds dbus.divzero_o, high alongside ready_o when the
//                     operation took the divide-by-zero path.
// -----------------------------------------------------------------------------
module div_seq #(
    parameter int WIDTH = 32
) (
    input  logic  clk,
    input  logic  rst,
    div_if.slave  dbus
);
    localparam int CNT_W = $clog2(WIDTH);

    typedef enum logic [1:0] {
        S_FREE   = 2'd0,
        S_BYZERO = 2'd1,
        S_ON     = 2'd2,
        S_END    = 2'd3
    } state_e;

    state_e               state_q, state_d;
    logic [WIDTH-1:0]     dvd_q, dvd_d;     // dividend shifting out, quotient shifting in
    logic [WIDTH-1:0]     dsr_q, dsr_d;     // |divisor|
    logic [WIDTH-1:0]     rem_q, rem_d;     // partial remainder
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 qneg_q, qneg_d;   // negate quotient at the end
    logic                 rneg_q, rneg_d;   // negate remainder at the end
    logic [2*WIDTH-1:0]   result_q, result_d;
    logic                 ready_q, ready_d;
`ifdef DIV_ZERO_FLAG_EN
    logic                 dz_q, dz_d;
`endif

    // Operand magnitudes, computed at issue so the iteration is purely unsigned.
    logic                 op1_neg, op2_neg;
    logic [WIDTH-1:0]     abs1, abs2;

    assign op1_neg = dbus.signed_div_i & dbus.opdata1_i[WIDTH-1];
    assign op2_neg = dbus.signed_div_i & dbus.opdata2_i[WIDTH-1];
    assign abs1    = op1_neg ? (~dbus.opdata1_i + 1'b1) : dbus.opdata1_i;
    assign abs2    = op2_neg ? (~dbus.opdata2_i + 1'b1) : dbus.opdata2_i;

    // One restoring step. rem_q < dsr_q always holds, so the shifted
    // remainder fits in WIDTH+1 bits and the borrow is the sign bit.
    logic [WIDTH:0]       rem_sh, diff;
    logic                 q_bit;
    logic [WIDTH-1:0]     rem_nx, dvd_nx, q_fix, r_fix;

    assign rem_sh = {rem_q, dvd_q[WIDTH-1]};
    assign diff   = rem_sh - {1'b0, dsr_q};
    assign q_bit  = ~diff[WIDTH];
    assign rem_nx = q_bit ? diff[WIDTH-1:0] : rem_sh[WIDTH-1:0];
    assign dvd_nx = {dvd_q[WIDTH-2:0], q_bit};
    // 0x80..0 / -1 wraps back to 0x80..0 here, which is the intended result.
    assign q_fix  = qneg_q ? (~dvd_nx + 1'b1) : dvd_nx;
    assign r_fix  = rneg_q ? (~rem_nx + 1'b1) : rem_nx;

    always_comb begin
        state_d  = state_q;
        dvd_d    = dvd_q;
        dsr_d    = dsr_q;
        rem_d    = rem_q;
        cnt_d    = cnt_q;
        qneg_d   = qneg_q;
        rneg_d   = rneg_q;
        result_d = result_q;
        ready_d  = ready_q;
`ifdef DIV_ZERO_FLAG_EN
        dz_d     = dz_q;
`endif
        case (state_q)
            S_FREE: begin
                if (dbus.start_i && !dbus.annul_i) begin
                    dvd_d   = abs1;
                    dsr_d   = abs2;
                    rem_d   = '0;
                    cnt_d   = '0;
                    qneg_d  = op1_neg ^ op2_neg;
                    rneg_d  = op1_neg;
                    state_d = (dbus.opdata2_i == '0) ? S_BYZERO : S_ON;
                end
            end
            S_BYZERO: begin
                if (dbus.annul_i) begin
                    state_d = S_FREE;
                end else begin
                    result_d = '0;
                    ready_d  = 1'b1;
`ifdef DIV_ZERO_FLAG_EN
                    dz_d     = 1'b1;
`endif
                    state_d  = S_END;
                end
            end
            S_ON: begin
                if (dbus.annul_i) begin
                    state_d = S_FREE;
                end else begin
                    dvd_d = dvd_nx;
                    rem_d = rem_nx;
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(WIDTH - 1)) begin
                        // Last step: publish the sign-corrected result directly.
                        result_d = {r_fix, q_fix};
                        ready_d  = 1'b1;
                        state_d  = S_END;
                    end
                end
            end
            S_END: begin
                // Annul is deliberately ignored: the handshake always completes.
                if (!dbus.start_i) begin
                    result_d = '0;
                    ready_d  = 1'b0;
`ifdef DIV_ZERO_FLAG_EN
                    dz_d     = 1'b0;
`endif
                    state_d  = S_FREE;
                end
            end
            default: state_d = S_FREE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_FREE;
            dvd_q    <= '0;
            dsr_q    <= '0;
            rem_q    <= '0;
            cnt_q    <= '0;
            qneg_q   <= 1'b0;
            rneg_q   <= 1'b0;
            result_q <= '0;
            ready_q  <= 1'b0;
`ifdef DIV_ZERO_FLAG_EN
            dz_q     <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            dvd_q    <= dvd_d;
            dsr_q    <= dsr_d;
            rem_q    <= rem_d;
            cnt_q    <= cnt_d;
            qneg_q   <= qneg_d;
            rneg_q   <= rneg_d;
            result_q <= result_d;
            ready_q  <= ready_d;
`ifdef DIV_ZERO_FLAG_EN
            dz_q     <= dz_d;
`endif
        end
    end

    assign dbus.result_o = result_q;
    assign dbus.ready_o  = ready_q;
    assign dbus.busy_o   = (state_q != S_FREE);
`ifdef DIV_ZERO_FLAG_EN
    assign dbus.divzero_o = dz_q;
`endif

endmodule
